// File: rtl/lfsr_seq_monitor_if.sv
// Sample and statistics bundle between the DFF feedback-counter harness and lfsr_seq_monitor.
// The harness drives the sample side and the monitor drives the statistics side.
interface lfsr_seq_monitor_if #(
    parameter int CNT_W = 5,
    parameter int ERR_W = 4
);
    logic             EN;
    logic [3:0]       Q;
    logic             CLR;
    logic [CNT_W-1:0] PERIOD;
    logic             PERIOD_VALID;
    logic             SEQ_ERR;
    logic [ERR_W-1:0] ERR_CNT;
    logic             LOCKUP;

    modport master (
        output EN, Q, CLR,
        input  PERIOD, PERIOD_VALID, SEQ_ERR, ERR_CNT, LOCKUP
    );

    modport slave (
        input  EN, Q, CLR,
        output PERIOD, PERIOD_VALID, SEQ_ERR, ERR_CNT, LOCKUP
    );
endinterface

// File: rtl/lfsr_seq_monitor.sv
// Checks that each enabled sample of the 4-bit feedback counter is the successor of the previous one.
// It also measures the lap period, counts mismatches and latches the all-zero lock-up state.
module lfsr_seq_monitor #(
    parameter int CNT_W = 5,
    parameter int ERR_W = 4
) (
    input logic              CLK,
    input logic              RST_bar,
    lfsr_seq_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       ref_q, ref_d;
    logic [3:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             lockup_q, lockup_d;

    function automatic logic [3:0] succ(input logic [3:0] s);
        return {s[1] ^ s[0], s[3], s[2], s[1]};
    endfunction

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
            lockup_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
            lockup_q  <= lockup_d;
        end
    end

    // A zero sample wins over every tracking decision, so LOCK is entered from any state.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        seq_err_d = seq_err_q;
        err_cnt_d = err_cnt_q;
        lockup_d  = lockup_q;

        if (bus.CLR) begin
            state_d   = IDLE;
            ref_d     = '0;
            prev_d    = '0;
            cnt_d     = '0;
            period_d  = '0;
            valid_d   = 1'b0;
            seq_err_d = 1'b0;
            err_cnt_d = '0;
            lockup_d  = 1'b0;
        end else if (bus.EN) begin
            if (bus.Q == 4'b0000) begin
                lockup_d = 1'b1;
                state_d  = LOCK;
            end else begin
                case (state_q)
                    IDLE: begin
                        ref_d   = bus.Q;
                        prev_d  = bus.Q;
                        cnt_d   = '0;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        prev_d = bus.Q;
                        if (bus.Q != succ(prev_q)) begin
                            // Resync on the unexpected sample; the stale PERIOD stays visible.
                            seq_err_d = 1'b1;
                            err_cnt_d = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + ERR_W'(1);
                            ref_d     = bus.Q;
                            cnt_d     = '0;
                            valid_d   = 1'b0;
                        end else if (bus.Q == ref_q) begin
                            period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                            valid_d  = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                        end
                    end
                    LOCK: ;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign bus.PERIOD       = period_q;
    assign bus.PERIOD_VALID = valid_q;
    assign bus.SEQ_ERR      = seq_err_q;
    assign bus.ERR_CNT      = err_cnt_q;
    assign bus.LOCKUP       = lockup_q;
endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// Self-checking bench for lfsr_seq_monitor against a lap-history reference model.
module tb_lfsr_seq_monitor;
    localparam int CNT_W   = 5;
    localparam int ERR_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int VW      = CNT_W + ERR_W + 3;

    logic CLK = 1'b0;
    logic RST_bar;
    int   checks = 0;
    int   fails  = 0;

    lfsr_seq_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();
    lfsr_seq_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (.CLK(CLK), .RST_bar(RST_bar), .bus(bus));

    always #5 CLK = ~CLK;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {bus.PERIOD, bus.PERIOD_VALID, bus.SEQ_ERR, bus.ERR_CNT, bus.LOCKUP};

    // Model: lap holds every sample since the last resync, lap[0] being the reference state.
    int         m_mode;
    logic [3:0] lap[$];
    int         m_period, m_err;
    bit         m_valid, m_seq_err, m_lock;
    logic [3:0] last_q = 4'h0;

    function automatic logic [3:0] next_state(input logic [3:0] s);
        int v;
        v = int'(s);
        return 4'((((v ^ (v >> 1)) & 1) * 8) + (v >> 1));
    endfunction

    function automatic logic [3:0] bad_sample(input logic [3:0] prev);
        logic [3:0] q;
        do q = 4'($urandom_range(1, 15)); while (q == next_state(prev));
        return q;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {CNT_W'(m_period), m_valid, m_seq_err, ERR_W'(m_err), m_lock};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        lap.delete();
        m_period = 0;
        m_err = 0;
        m_valid = 1'b0;
        m_seq_err = 1'b0;
        m_lock = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [3:0] q, input bit clr);
        if (clr) begin
            model_reset();
        end else if (en) begin
            if (q == 4'h0) begin
                m_lock = 1'b1;
                m_mode = 2;
            end else if (m_mode == 0) begin
                lap = {q};
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (q != next_state(lap[$])) begin
                    m_seq_err = 1'b1;
                    m_err = (m_err + 1 > ERR_MAX) ? ERR_MAX : m_err + 1;
                    m_valid = 1'b0;
                    lap = {q};
                end else if (q == lap[0]) begin
                    m_period = (lap.size() > CNT_MAX) ? CNT_MAX : lap.size();
                    m_valid = 1'b1;
                    lap = {q};
                end else begin
                    lap.push_back(q);
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit en, input logic [3:0] q, input bit clr);
        @(negedge CLK);
        bus.EN = en;
        bus.Q = q;
        bus.CLR = clr;
        @(posedge CLK);
        #1;
        model_step(en, q, clr);
        if (en && !clr) last_q = q;
        bus.EN = 1'b0;
        bus.CLR = 1'b0;
    endtask

    task automatic test_reset();
        RST_bar = 1'b0;
        bus.EN = 1'b1;
        bus.Q = 4'($urandom_range(1, 15));
        bus.CLR = 1'b0;
        model_reset();
        #3;
        checks++;
        if (dut_vec !== '0) begin
            fails++;
            $display("[TB] FAIL reset_initial: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        @(posedge CLK);
        #1;
        checks++;
        if (dut_vec !== '0) begin
            fails++;
            $display("[TB] FAIL reset_held: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        bus.EN = 1'b0;
        @(negedge CLK);
        RST_bar = 1'b1;
    endtask

    task automatic test_legal_run();
        logic [3:0] s = 4'b0100;
        apply_stimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 31; i++) begin
            apply_stimulus(1'b1, s, 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("[TB] FAIL legal_run[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
            if (i == 15 || i == 30) begin
                checks++;
                if (bus.PERIOD !== CNT_W'(15) || bus.PERIOD_VALID !== 1'b1 ||
                    bus.SEQ_ERR !== 1'b0 || bus.ERR_CNT !== '0) begin
                    fails++;
                    $display("[TB] FAIL legal_period[%0d]: got period %0d valid %b err %b cnt %0d expected 15 1 0 0",
                             i, bus.PERIOD, bus.PERIOD_VALID, bus.SEQ_ERR, bus.ERR_CNT);
                end
            end
            s = next_state(s);
        end
    endtask

    task automatic test_error_injection();
        logic [3:0] seq [4];
        logic [3:0] s;
        seq = '{4'b0100, 4'b0010, 4'b1001, 4'b1111};
        apply_stimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, seq[i], 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("[TB] FAIL inject[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bus.SEQ_ERR !== 1'b1 || bus.ERR_CNT !== ERR_W'(1) || bus.PERIOD_VALID !== 1'b0) begin
            fails++;
            $display("[TB] FAIL inject_flags: got err %b cnt %0d valid %b expected 1 1 0",
                     bus.SEQ_ERR, bus.ERR_CNT, bus.PERIOD_VALID);
        end
        s = next_state(4'b1111);
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b1, s, 1'b0);
            s = next_state(s);
        end
        checks++;
        if (bus.PERIOD !== CNT_W'(15) || bus.PERIOD_VALID !== 1'b1 || dut_vec !== model_vec()) begin
            fails++;
            $display("[TB] FAIL inject_recover: got %h (period %0d valid %b) expected %h (period 15 valid 1)",
                     dut_vec, bus.PERIOD, bus.PERIOD_VALID, model_vec());
        end
    endtask

    task automatic test_lockup();
        logic [3:0] s = 4'($urandom_range(1, 15));
        apply_stimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, s, 1'b0);
            s = next_state(s);
        end
        apply_stimulus(1'b1, bad_sample(last_q), 1'b0);
        apply_stimulus(1'b1, 4'h0, 1'b0);
        checks++;
        if (bus.LOCKUP !== 1'b1 || dut_vec !== model_vec()) begin
            fails++;
            $display("[TB] FAIL lockup_set: got %h expected %h", dut_vec, model_vec());
        end
        s = 4'($urandom_range(1, 15));
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, (i % 3 == 2) ? bad_sample(s) : s, 1'b0);
            s = next_state(s);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("[TB] FAIL lockup_frozen[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bus.PERIOD !== CNT_W'(15) || bus.ERR_CNT !== ERR_W'(1) || bus.LOCKUP !== 1'b1) begin
            fails++;
            $display("[TB] FAIL lockup_hold: got period %0d cnt %0d lock %b expected 15 1 1",
                     bus.PERIOD, bus.ERR_CNT, bus.LOCKUP);
        end
        apply_stimulus(1'b0, 4'h0, 1'b1);
        checks++;
        if (dut_vec !== '0) begin
            fails++;
            $display("[TB] FAIL lockup_clear: got %h expected %h", dut_vec, {VW{1'b0}});
        end
    endtask

    task automatic test_en_gaps();
        logic [3:0] s = 4'($urandom_range(1, 15));
        logic [3:0] junk;
        apply_stimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, s, 1'b0);
            s = next_state(s);
            for (int g = 0; g < 3; g++) begin
                case ($urandom_range(0, 2))
                    0: junk = 4'h0;
                    1: junk = 4'hF;
                    default: junk = 4'($urandom_range(0, 15));
                endcase
                apply_stimulus(1'b0, junk, 1'b0);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("[TB] FAIL en_gap[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bus.PERIOD !== CNT_W'(15) || bus.PERIOD_VALID !== 1'b1 || bus.SEQ_ERR !== 1'b0 || bus.LOCKUP !== 1'b0) begin
            fails++;
            $display("[TB] FAIL en_gap_lap: got period %0d valid %b err %b lock %b expected 15 1 0 0",
                     bus.PERIOD, bus.PERIOD_VALID, bus.SEQ_ERR, bus.LOCKUP);
        end
    endtask

    task automatic test_saturation();
        apply_stimulus(1'b0, 4'h0, 1'b1);
        apply_stimulus(1'b1, 4'($urandom_range(1, 15)), 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, bad_sample(last_q), 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("[TB] FAIL saturate[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if (bus.ERR_CNT !== ERR_W'(ERR_MAX) || bus.SEQ_ERR !== 1'b1) begin
            fails++;
            $display("[TB] FAIL saturate_final: got cnt %0d err %b expected %0d 1", bus.ERR_CNT, bus.SEQ_ERR, ERR_MAX);
        end
    endtask

    task automatic test_reset_race();
        logic [3:0] s = 4'($urandom_range(1, 15));
        apply_stimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, s, 1'b0);
            s = next_state(s);
        end
        #2;
        RST_bar = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        @(negedge CLK);
        RST_bar = 1'b1;
        apply_stimulus(1'b1, bad_sample(last_q), 1'b0);
        checks++;
        if (dut_vec !== model_vec() || bus.SEQ_ERR !== 1'b0) begin
            fails++;
            $display("[TB] FAIL post_reset_first: got %h expected %h", dut_vec, model_vec());
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, next_state(last_q), 1'b0);
        apply_stimulus(1'b1, 4'h0, 1'b1);
        checks++;
        if (bus.LOCKUP !== 1'b0 || dut_vec !== '0) begin
            fails++;
            $display("[TB] FAIL clr_race: got %h expected %h", dut_vec, {VW{1'b0}});
        end
        apply_stimulus(1'b1, 4'($urandom_range(1, 15)), 1'b0);
        apply_stimulus(1'b1, next_state(last_q), 1'b0);
        checks++;
        if (dut_vec !== model_vec() || bus.SEQ_ERR !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clr_race_idle: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0] q;
        bit en, clr;
        int c;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 99) < 80);
            clr = ($urandom_range(0, 99) < 2);
            c = $urandom_range(0, 99);
            if (c < 65) begin
                q = next_state(last_q);
                if (q == 4'h0) q = 4'($urandom_range(1, 15));
            end else if (c < 70) begin
                q = 4'h0;
            end else begin
                q = 4'($urandom_range(0, 15));
            end
            apply_stimulus(en, q, clr);
            checks++;
            if (dut_vec !== model_vec()) begin
                fails++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_legal_run();
        test_error_injection();
        test_lockup();
        test_en_gaps();
        test_saturation();
        test_reset_race();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
